// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and elaboration-time sizing helpers for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher_channel.sv
// One channel: stretches each accepted pulse into a fixed high window followed by a fixed low gap.
// Latency 1 cycle; no backpressure -- pulses during a window queue up to PENDING_MAX, then drop and flag overflow.
module pulse_stretcher_channel
  import pulse_stretcher_pkg::*;
#(
  parameter int STRETCH_CYCLES = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int PENDING_MAX    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pulse,
  input  logic i_clear_overflow,
  output logic o_level,
  output logic o_busy,
  output logic o_overflow
);

  localparam int CW = clog2(max2(STRETCH_CYCLES, GAP_CYCLES) + 1);
  localparam int PW = clog2(PENDING_MAX + 1);

  localparam logic [CW-1:0] C_STRETCH_LOAD = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] C_GAP_LOAD     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_ONE      = CW'(1);
  localparam logic [PW-1:0] C_PEND_MAX     = PW'(PENDING_MAX);
  localparam logic [PW-1:0] C_PEND_ONE     = PW'(1);
  localparam logic [PW:0]   C_P_ONE        = (PW + 1)'(1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pending;
  logic          r_level;
  logic          r_busy;
  logic          r_overflow;

  logic          w_cnt_zero;
  logic          w_terminal;
  logic          w_pend_full;
  logic          w_drop;
  logic [PW:0]   w_p;

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_terminal  = (r_state == GAP) && w_cnt_zero;
  assign w_pend_full = (r_pending == C_PEND_MAX);
  // The last gap cycle folds its own pulse into the replay decision, so it never drops.
  assign w_drop      = i_pulse && w_pend_full && (r_state != IDLE) && !w_terminal;
  assign w_p         = {1'b0, r_pending} + {{PW{1'b0}}, i_pulse};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_level    <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_clear_overflow) begin
        r_overflow <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (i_pulse) begin
            r_state <= HIGH;
            r_cnt   <= C_STRETCH_LOAD;
            r_level <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        HIGH: begin
          if (i_pulse && !w_pend_full) r_pending <= r_pending + C_PEND_ONE;
          if (w_cnt_zero) begin
            r_state <= GAP;
            r_cnt   <= C_GAP_LOAD;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        GAP: begin
          if (!w_cnt_zero) begin
            if (i_pulse && !w_pend_full) r_pending <= r_pending + C_PEND_ONE;
            r_cnt <= r_cnt - C_CNT_ONE;
          end else if (w_p != '0) begin
            r_state   <= HIGH;
            r_cnt     <= C_STRETCH_LOAD;
            r_pending <= PW'(w_p - C_P_ONE);
            r_level   <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_level <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_level    = r_level;
  assign o_busy     = r_busy;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/pulse_stretcher.sv
// WIDTH independent pulse-stretcher channels side by side; outputs are the per-channel bits concatenated.
// Latency 1 cycle; no backpressure -- each channel queues or drops on its own.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int STRETCH_CYCLES = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int PENDING_MAX    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pulse_in,
  input  logic [WIDTH-1:0] clear_overflow,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] overflow
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    pulse_stretcher_channel #(
      .STRETCH_CYCLES (STRETCH_CYCLES),
      .GAP_CYCLES     (GAP_CYCLES),
      .PENDING_MAX    (PENDING_MAX)
    ) u_ch (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_pulse          (pulse_in[g]),
      .i_clear_overflow (clear_overflow[g]),
      .o_level          (level_out[g]),
      .o_busy           (busy[g]),
      .o_overflow       (overflow[g])
    );
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: hand-derived vector table and sequences, then random traffic against a window-schedule model.
module tb_pulse_stretcher;

  localparam int W  = 2;
  localparam int S  = 4;
  localparam int G  = 2;
  localparam int PM = 2;
  localparam int HIST = 512;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] pulse_in;
  logic [W-1:0] clear_overflow;
  logic [W-1:0] level_out;
  logic [W-1:0] busy;
  logic [W-1:0] overflow;

  pulse_stretcher #(
    .WIDTH          (W),
    .STRETCH_CYCLES (S),
    .GAP_CYCLES     (G),
    .PENDING_MAX    (PM)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pulse_in       (pulse_in),
    .clear_overflow (clear_overflow),
    .level_out      (level_out),
    .busy           (busy),
    .overflow       (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] p;
    logic [1:0] c;
    logic [1:0] lvl;
    logic [1:0] bsy;
    logic [1:0] ovf;
  } vec_t;

  vec_t tbl[$];

  int         n_vec;
  int         n_err;
  int         edge_no;
  int         rise0;
  logic       prev0;
  // Model: every accepted pulse becomes a window start edge; a channel's state is its list of starts.
  int         st[W][HIST];
  int         nst[W];
  logic [1:0] m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < W; ch++) nst[ch] = 0;
    m_ovf = '0;
  endtask

  task automatic model_edge(input logic [1:0] p, input logic [1:0] c);
    for (int ch = 0; ch < W; ch++) begin
      bit drop;
      int last, cand, npend;
      drop = 0;
      if (p[ch]) begin
        last  = (nst[ch] > 0) ? st[ch][nst[ch]-1] : -1000;
        cand  = (edge_no > last + S + G) ? edge_no : last + S + G;
        npend = 0;
        for (int i = 0; i < nst[ch]; i++) if (st[ch][i] > edge_no) npend++;
        if (cand != edge_no && npend >= PM) drop = 1;
        else if (nst[ch] < HIST) begin
          st[ch][nst[ch]] = cand;
          nst[ch]++;
        end
      end
      if (drop) m_ovf[ch] = 1'b1;
      else if (c[ch]) m_ovf[ch] = 1'b0;
    end
  endtask

  // Expected outputs after edge e, derived from the window start list.
  function automatic logic [1:0] exp_level(input int e);
    logic [1:0] r;
    r = '0;
    for (int ch = 0; ch < W; ch++)
      for (int i = (nst[ch] > 4 ? nst[ch] - 4 : 0); i < nst[ch]; i++)
        if (st[ch][i] <= e && e < st[ch][i] + S) r[ch] = 1'b1;
    return r;
  endfunction

  function automatic logic [1:0] exp_busy(input int e);
    logic [1:0] r;
    r = '0;
    for (int ch = 0; ch < W; ch++)
      for (int i = (nst[ch] > 4 ? nst[ch] - 4 : 0); i < nst[ch]; i++)
        if ((st[ch][i] <= e && e < st[ch][i] + S + G) || st[ch][i] > e) r[ch] = 1'b1;
    return r;
  endfunction

  task automatic step(input logic [1:0] p, input logic [1:0] c);
    pulse_in       = p;
    clear_overflow = c;
    @(posedge clk);
    if (rst_n) model_edge(p, c);
    else model_reset();
    edge_no++;
    @(negedge clk);
    if (level_out[0] && !prev0) rise0++;
    prev0 = level_out[0];
  endtask

  task automatic add(input logic [1:0] p, input logic [1:0] l, input logic [1:0] b, input int n);
    vec_t v;
    v.p = p; v.c = 2'b00; v.lvl = l; v.bsy = b; v.ovf = 2'b00;
    repeat (n) tbl.push_back(v);
  endtask

  initial begin
    logic [20:0] pat_l;
    logic [20:0] pat_b;
    logic [20:0] pat_o;
    logic [1:0]  rp;
    logic [1:0]  rc;
    int          b_start;
    int          thr;

    n_vec = 0; n_err = 0; edge_no = 0; rise0 = 0; prev0 = 1'b0;
    rst_n = 1'b0; pulse_in = 2'b11; clear_overflow = 2'b00;
    model_reset();

    // Reset held with pulses present, released mid-cycle, then async reset mid-window.
    repeat (3) begin
      step(2'b11, 2'b00);
      chk("rst_level", level_out, 2'b00);
      chk("rst_busy", busy, 2'b00);
      chk("rst_ovf", overflow, 2'b00);
    end
    rst_n = 1'b1;
    repeat (5) begin
      step(2'b00, 2'b00);
      chk("idle_level", level_out, 2'b00);
      chk("idle_busy", busy, 2'b00);
      chk("idle_ovf", overflow, 2'b00);
    end
    step(2'b01, 2'b00);
    chk("pre_async_level", level_out, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_level", level_out, 2'b00);
    chk("async_busy", busy, 2'b00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      step(2'b00, 2'b00);
      chk("no_replay_level", level_out, 2'b00);
      chk("no_replay_busy", busy, 2'b00);
    end

    // Vector table: single pulse; pulse in gap terminal cycle; queued second pulse.
    add(2'b01, 2'b01, 2'b01, 1); add(2'b00, 2'b01, 2'b01, 3);
    add(2'b00, 2'b00, 2'b01, 2); add(2'b00, 2'b00, 2'b00, 2);
    add(2'b01, 2'b01, 2'b01, 1); add(2'b00, 2'b01, 2'b01, 3);
    add(2'b00, 2'b00, 2'b01, 2); add(2'b01, 2'b01, 2'b01, 1);
    add(2'b00, 2'b01, 2'b01, 3); add(2'b00, 2'b00, 2'b01, 2);
    add(2'b00, 2'b00, 2'b00, 1);
    b_start = tbl.size();
    add(2'b01, 2'b01, 2'b01, 1); add(2'b00, 2'b01, 2'b01, 1);
    add(2'b01, 2'b01, 2'b01, 1); add(2'b00, 2'b01, 2'b01, 1);
    add(2'b00, 2'b00, 2'b01, 2); add(2'b00, 2'b01, 2'b01, 4);
    add(2'b00, 2'b00, 2'b01, 2); add(2'b00, 2'b00, 2'b00, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == b_start) rise0 = 0;
      step(tbl[i].p, tbl[i].c);
      chk($sformatf("tbl%0d_level", i), level_out, tbl[i].lvl);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
    end
    chk("queued_rising_edges", rise0, 2);

    // Held pulse for 3 cycles: windows at edges 0, 6, 12; busy through edge 17.
    pat_l = 21'b0_0000_1111_00_1111_00_1111;
    pat_b = 21'h03FFFF;
    for (int k = 0; k < 20; k++) begin
      step(k < 3 ? 2'b01 : 2'b00, 2'b00);
      chk($sformatf("held%0d_level", k), level_out, {1'b0, pat_l[k]});
      chk($sformatf("held%0d_busy", k), busy, {1'b0, pat_b[k]});
    end

    // Four pulses on ch1 with pending limit 2: fourth dropped, overflow until cleared at k=20.
    pat_o = 21'h0FFFF8;
    for (int k = 0; k < 21; k++) begin
      step(k < 4 ? 2'b10 : 2'b00, k == 20 ? 2'b10 : 2'b00);
      chk($sformatf("ovf%0d_level", k), level_out, {pat_l[k], 1'b0});
      chk($sformatf("ovf%0d_busy", k), busy, {pat_b[k], 1'b0});
      chk($sformatf("ovf%0d_flag", k), overflow, {pat_o[k], 1'b0});
    end

    repeat (3) step(2'b10, 2'b00);
    step(2'b10, 2'b10);
    chk("set_beats_clear", overflow, 2'b10);
    step(2'b00, 2'b10);
    chk("clear_after", overflow, 2'b00);
    repeat (20) step(2'b00, 2'b00);
    chk("drained_busy", busy, 2'b00);

    // Random traffic against the window-schedule model.
    for (int k = 0; k < 1200; k++) begin
      thr = ((k % 200) < 100) ? 4 : 1;
      rp[0] = ($urandom_range(0, 9) < thr);
      rp[1] = ($urandom_range(0, 9) < thr);
      rc[0] = ($urandom_range(0, 15) == 0);
      rc[1] = ($urandom_range(0, 15) == 0);
      step(rp, rc);
      chk($sformatf("rnd%0d_level", k), level_out, exp_level(edge_no - 1));
      chk($sformatf("rnd%0d_busy", k), busy, exp_busy(edge_no - 1));
      chk($sformatf("rnd%0d_ovf", k), overflow, m_ovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
